uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver types: state encoding and bit-timing helpers.
// Optional parity state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // Bit period rounded to the nearest whole clock.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int calc_half(input int clk_hz, input int baud);
        return calc_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Flop-based first-word-fall-through FIFO: head visible on pop_data while not empty.
// Push is accepted when not full, or when full with a simultaneous pop; otherwise ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO and sticky error flags; even parity with UART_RX_PARITY_EN.
// Byte visible the cycle after the stop-bit sample; a full FIFO without a pop drops the byte and sets overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ser_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    input  logic                          err_clr
);

    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = calc_half(CLK_HZ, BAUD);
    localparam int CW   = $clog2(DIV + 1);

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          half_tick;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          frame_set;
    logic          ovr_set;
    logic          par_bad;

    assign rx_s      = sync[1];
    assign tick      = (cnt == CW'(DIV - 1));
    assign half_tick = (cnt == CW'(HALF - 1));
    assign push      = (state == ST_STOP) && tick && rx_s && !par_bad;
    assign frame_set = (state == ST_STOP) && tick && !rx_s;
    assign pop       = rx_valid && rx_ready;
    assign ovr_set   = push && fifo_full && !pop;
    assign rx_valid  = !fifo_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            sync    <= {sync[0], ser_rx};
            rx_prev <= rx_s;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (half_tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        // Line back high at mid-start means a glitch, not a frame.
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= ST_PARITY;
`else
                        if (bit_idx == 3'd7) state <= ST_STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        cnt     <= '0;
                        par_bad <= (rx_s != ^shreg);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Setting wins over a coincident clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_set | (frame_err & ~err_clr);
            overrun   <= ovr_set | (overrun & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_set;
    assign par_set = (state == ST_PARITY) && tick && (rx_s != ^shreg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) parity_err <= 1'b0;
        else         parity_err <= par_set | (parity_err & ~err_clr);
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shreg),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (rx_data),
        .empty     (fifo_empty),
        .level     (rx_level)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx; sender computes expected bytes from frame rules.
module tb_uart_rx;

    localparam int CLK_HZ     = 1600000;
    localparam int BAUD       = 100000;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_CLKS   = (CLK_HZ + BAUD / 2) / BAUD;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] rx_level;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       err_clr;

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         valid_cycles = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] held = '0;
    bit         rand_ready_en = 1'b0;
    bit         ovr_expected = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_level   (rx_level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        ser_rx = b;
        idle(BIT_CLKS);
    endtask

    // A frame yields a byte only with a high stop bit and (when enabled) even parity.
    task automatic send(input logic [7:0] d, input logic stop_val, input logic par_val);
        logic good;
        good = stop_val;
`ifdef UART_RX_PARITY_EN
        good = good && (par_val == ^d);
`endif
        if (good) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
            else                           ovr_expected = 1'b1;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_val);
`endif
        drive_bit(stop_val);
        drive_bit(1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
    endtask

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            rx_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (rx_valid) valid_cycles++;
            if (hold_prev && rx_valid) check("data_hold", 32'(rx_data), 32'(held));
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                end
            end
            hold_prev = rx_valid && !rx_ready;
            held      = rx_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        resetn   = 1'b0;
        ser_rx   = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        idle(3);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_level", 32'(rx_level), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        resetn = 1'b1;
        idle(BIT_CLKS);

        // Single clean byte consumed immediately: one-cycle valid pulse.
        valid_cycles = 0;
        send(8'h55, 1'b1, ^8'h55);
        idle(4);
        check("pulse_cycles", 32'(valid_cycles), 32'd1);
        check("clean_frame_err", 32'(frame_err), 32'd0);
        check("clean_overrun", 32'(overrun), 32'd0);
        check("clean_parity_err", 32'(parity_err), 32'd0);
        check("clean_pending", 32'(exp_q.size()), 32'd0);

        // Short low glitch is a false start.
        ser_rx = 1'b0;
        idle(BIT_CLKS / 4);
        ser_rx = 1'b1;
        idle(2 * BIT_CLKS);
        check("glitch_level", 32'(rx_level), 32'd0);
        check("glitch_valid_cycles", 32'(valid_cycles), 32'd1);
        check("glitch_frame_err", 32'(frame_err), 32'd0);

        // Low stop bit: byte discarded, frame_err sticky until cleared.
        send(8'hA3, 1'b0, ^8'hA3);
        idle(4);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_level", 32'(rx_level), 32'd0);
        send(8'h12, 1'b1, ^8'h12);
        drain();
        check("ferr_sticky", 32'(frame_err), 32'd1);
        pulse_clr();
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // Random bytes with random consumer backpressure.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b1, ^b);
        end
        @(posedge clk);
        rand_ready_en = 1'b0;
        #2;
        rx_ready = 1'b1;
        drain();
        check("rand_overrun", 32'(overrun), 32'd0);

        // Fill the FIFO with no consumer; the 17th byte overruns.
        rx_ready     = 1'b0;
        ovr_expected = 1'b0;
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            b = 8'(i);
            send(b, 1'b1, ^b);
        end
        idle(4);
        check("full_level", 32'(rx_level), 32'(exp_q.size()));
        check("full_level_abs", 32'(rx_level), 32'(FIFO_DEPTH));
        check("overrun_set", 32'(overrun), 32'(ovr_expected));
        check("full_head", 32'(rx_data), 32'(exp_q[0]));
        rx_ready = 1'b1;
        drain();
        check("drained_level", 32'(rx_level), 32'd0);
        pulse_clr();
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Reset in the middle of 0xFF (during data bit 4), then 0x3C.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        idle(BIT_CLKS / 2);
        resetn = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_level", 32'(rx_level), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        idle(5 * BIT_CLKS);
        resetn = 1'b1;
        idle(BIT_CLKS);
        valid_cycles = 0;
        send(8'h3C, 1'b1, ^8'h3C);
        drain();
        check("midrst_bytes", 32'(valid_cycles), 32'd1);
        check("midrst_after_level", 32'(rx_level), 32'd0);

`ifdef UART_RX_PARITY_EN
        send(8'h01, 1'b1, 1'b0);
        idle(4);
        check("par_err_set", 32'(parity_err), 32'd1);
        check("par_err_level", 32'(rx_level), 32'd0);
        send(8'h01, 1'b1, 1'b1);
        drain();
        pulse_clr();
        check("par_err_cleared", 32'(parity_err), 32'd0);
`else
        check("par_err_tied", 32'(parity_err), 32'd0);
`endif

        idle(4);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
